// File: rtl/link_pkg.sv
`default_nettype none
// ============================================================================
// Module : link_pkg
// Shared types for both ends of the 4-byte free/put byte-stream link.
// Rev    : 1.0  initial release
// ============================================================================
package link_pkg;

    localparam int BEATS    = 4;
    localparam int c_BEAT_W = $clog2(BEATS);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
    } pay;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

    // Beat index 0 is the most significant byte, so beats go out a, b, c, d.
    function automatic logic [7:0] pay_byte(input pay msg, input logic [c_BEAT_W-1:0] idx);
        logic [7:0] w_byte;
        case (idx)
            2'd0:    w_byte = msg.a;
            2'd1:    w_byte = msg.b;
            2'd2:    w_byte = msg.c;
            default: w_byte = msg.d;
        endcase
        return w_byte;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msg_tx_queue_if.sv
`default_nettype none
// ============================================================================
// Module : msg_tx_queue_if
// Message-in / byte-out port bundle of the queued link transmitter.
// Rev    : 1.0  initial release
// ============================================================================
interface msg_tx_queue_if #(
    parameter int DEPTH = 4
);
    import link_pkg::*;

    logic                   in_valid;
    pay                     in_msg;
    logic                   in_ready;
    logic                   free;
    logic                   put;
    logic [7:0]             payload;
    logic                   sent;
    logic [$clog2(DEPTH):0] level;

    modport master (
        output in_valid, in_msg, free,
        input  in_ready, put, payload, sent, level
    );

    modport slave (
        input  in_valid, in_msg, free,
        output in_ready, put, payload, sent, level
    );

endinterface
`default_nettype wire

// File: rtl/msg_fifo.sv
`default_nettype none
// ============================================================================
// Module : msg_fifo
// Small synchronous FIFO with combinational head read and explicit count.
// Rev    : 1.0  initial release
// ============================================================================
module msg_fifo
    import link_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type ELEM_T = pay
) (
    input  logic                   ck,
    input  logic                   r,
    input  logic                   push,
    input  logic                   pop,
    input  ELEM_T                  wdata,
    output ELEM_T                  rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    ELEM_T               r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                w_do_push;
    logic                w_do_pop;

    // A full FIFO refuses a push even when a pop lands on the same edge.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rptr];

    always_ff @(posedge ck) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge ck) begin
        if (r) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/msg_tx_queue.sv
`default_nettype none
// ============================================================================
// Module : msg_tx_queue
// Buffers whole messages and serializes each as four put beats to the link.
// Rev    : 1.0  initial release
// ============================================================================
module msg_tx_queue
    import link_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           ck,
    input  logic           r,
    msg_tx_queue_if.slave  bus
);

    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    tx_state_t             r_state;
    logic [c_BEAT_W-1:0]   r_beat;
    logic                  r_put;
    logic [7:0]            r_payload;
    logic                  r_sent;

    pay                    w_head;
    logic [c_CNT_W-1:0]    w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;

    // The head is released on the edge that registers beat d, never earlier.
    assign w_pop = (r_state == SEND) && (r_beat == c_BEAT_W'(BEATS - 1));

    msg_fifo #(
        .DEPTH  (DEPTH),
        .ELEM_T (pay)
    ) u_fifo (
        .ck    (ck),
        .r     (r),
        .push  (bus.in_valid),
        .pop   (w_pop),
        .wdata (bus.in_msg),
        .rdata (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign bus.in_ready = !w_full;
    assign bus.level    = w_count;
    assign bus.put      = r_put;
    assign bus.payload  = r_payload;
    assign bus.sent     = r_sent;

    always_ff @(posedge ck) begin
        if (r) begin
            r_state   <= IDLE;
            r_beat    <= '0;
            r_put     <= 1'b0;
            r_payload <= '0;
            r_sent    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_put     <= 1'b0;
                    r_payload <= '0;
                    r_sent    <= 1'b0;
                    r_beat    <= '0;
                    if (!w_empty && bus.free) begin
                        r_state <= SEND;
                    end
                end
                // free is deliberately not looked at here: a started message always completes.
                SEND: begin
                    r_put     <= 1'b1;
                    r_payload <= pay_byte(w_head, r_beat);
                    r_sent    <= 1'b0;
                    r_beat    <= r_beat + c_BEAT_W'(1);
                    if (r_beat == c_BEAT_W'(BEATS - 1)) begin
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    r_put     <= 1'b0;
                    r_payload <= '0;
                    r_sent    <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    r_put     <= 1'b0;
                    r_payload <= '0;
                    r_sent    <= 1'b0;
                    r_beat    <= '0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
